// File: rtl/imem_rr_server.sv
// imem_rr_server: round-robin fetch arbiter in front of one synchronous
// instruction memory port. A MEM_LAT-deep tag pipeline tracks the granted
// core so each returning word is steered back to the core that issued it.
module imem_rr_server #(
    parameter int N_PORTS = 3,
    parameter int AW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORTS-1:0]       req_valid,
    input  logic [N_PORTS-1:0][31:0] req_addr,
    output logic [N_PORTS-1:0]       req_ready,
    output logic [N_PORTS-1:0]       rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     mem_en,
    output logic [AW-1:0]            mem_addr,
    input  logic [31:0]              mem_rdata
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [PW-1:0]               ptr_q, ptr_d;
    logic [MEM_LAT-1:0]          vld_pipe_q, vld_pipe_d;
    logic [MEM_LAT-1:0][PW-1:0]  tag_pipe_q, tag_pipe_d;

    logic          gnt_found;
    logic [PW-1:0] gnt_idx;
    int            cand;
    int            nxt;

    // Only the word-address bits reach memory; the rest are don't-care.
    logic unused_addr;
    assign unused_addr = ^req_addr;

    // Round-robin search starting at ptr; idle requesters are simply skipped.
    // Grants are forced off while reset is held so nothing leaks out.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        req_ready = '0;
        mem_en    = 1'b0;
        mem_addr  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_PORTS) cand = cand - N_PORTS;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(cand);
            end
        end
        if (gnt_found && rst) begin
            req_ready[gnt_idx] = 1'b1;
            mem_en             = 1'b1;
            mem_addr           = req_addr[gnt_idx][AW+1:2];
        end
    end

    // Next pointer sits just past the granted port; tags shift one stage per cycle.
    always_comb begin
        nxt   = int'(gnt_idx) + 1;
        if (nxt >= N_PORTS) nxt = 0;
        ptr_d = mem_en ? PW'(nxt) : ptr_q;
        vld_pipe_d    = '0;
        tag_pipe_d    = '0;
        vld_pipe_d[0] = mem_en;
        tag_pipe_d[0] = gnt_idx;
        for (int s = 1; s < MEM_LAT; s++) begin
            vld_pipe_d[s] = vld_pipe_q[s-1];
            tag_pipe_d[s] = tag_pipe_q[s-1];
        end
    end

    // State registers; reset drops every in-flight fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
        end
    end

    // Last tag stage decodes to the one-hot response strobe; data is passthrough.
    always_comb begin
        rsp_valid = '0;
        if (vld_pipe_q[MEM_LAT-1]) rsp_valid[tag_pipe_q[MEM_LAT-1]] = 1'b1;
        rsp_data = mem_rdata;
    end

endmodule
